isp_awb: RTL

- White-balance gain and statistics stage directly downstream of the demosaic stage in the ISP pipeline.
- Consumes the demosaic RGB stream (dm_r_o/dm_g_o/dm_b_o, dm_href_o, dm_vsync_o) and applies per-channel digital gains, with frame-synchronous gain update and saturation.
- Accumulates per-frame pre-gain R/G/B sums and a pixel count, which firmware reads to compute the next frame's gains.

---
 rtl/isp_awb.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/isp_awb.sv
// White-balance stage: per-channel frame-synchronous gains with rounding and saturation,
// plus per-frame pre-gain R/G/B sums and pixel count for firmware AWB.
module isp_awb #(
   parameter int DATA_W    = 8,
   parameter int GAIN_W    = 8,
   parameter int GAIN_FRAC = 6,
   parameter int SUM_W     = 32
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              awb_en,
   input  logic [GAIN_W-1:0] r_gain,
   input  logic [GAIN_W-1:0] g_gain,
   input  logic [GAIN_W-1:0] b_gain,
   input  logic [DATA_W-1:0] in_r,
   input  logic [DATA_W-1:0] in_g,
   input  logic [DATA_W-1:0] in_b,
   input  logic              in_href,
   input  logic              in_vsync,
   output logic [DATA_W-1:0] awb_r_o,
   output logic [DATA_W-1:0] awb_g_o,
   output logic [DATA_W-1:0] awb_b_o,
   output logic              awb_href_o,
   output logic              awb_vsync_o,
   output logic [SUM_W-1:0]  r_sum,
   output logic [SUM_W-1:0]  g_sum,
   output logic [SUM_W-1:0]  b_sum,
   output logic [SUM_W-1:0]  pix_cnt,
   output logic              stat_valid
);

   localparam int                PROD_W  = DATA_W + GAIN_W;
   localparam logic [GAIN_W-1:0] UNITY   = GAIN_W'(1 << GAIN_FRAC);
   localparam logic [PROD_W:0]   RND     = (PROD_W+1)'(1 << (GAIN_FRAC - 1));
   localparam logic [PROD_W:0]   MAX_PIX = (PROD_W+1)'((1 << DATA_W) - 1);

   // Round-half-up to integer, then clamp to the pixel range.
   function automatic logic [DATA_W-1:0] f_round_sat(input logic [PROD_W-1:0] prod);
      logic [PROD_W:0] v;
      v = ({1'b0, prod} + RND) >> GAIN_FRAC;
      if (v > MAX_PIX) return '1;
      return v[DATA_W-1:0];
   endfunction

   function automatic logic [SUM_W-1:0] f_sat_add(input logic [SUM_W-1:0]  acc,
                                                  input logic [DATA_W-1:0] inc);
      logic [SUM_W:0] s;
      s = {1'b0, acc} + (SUM_W+1)'(inc);
      if (s[SUM_W]) return '1;
      return s[SUM_W-1:0];
   endfunction

   logic              r_vsync_prev;
   logic              r_first_frame;
   logic [GAIN_W-1:0] r_wgain_r, r_wgain_g, r_wgain_b;
   logic [PROD_W-1:0] r_prod_r, r_prod_g, r_prod_b;
   logic [DATA_W-1:0] r_raw_r, r_raw_g, r_raw_b;
   logic              r_en_s1, r_href_s1, r_vsync_s1;
   logic [SUM_W-1:0]  r_acc_r, r_acc_g, r_acc_b, r_acc_cnt;

   logic              w_fe;
   logic [DATA_W-1:0] w_pix_r, w_pix_g, w_pix_b;

   assign w_fe = in_vsync & ~r_vsync_prev;

   // Working gains are shadowed so mid-frame config writes never tear a frame.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_prev <= 1'b0;
         r_wgain_r    <= UNITY;
         r_wgain_g    <= UNITY;
         r_wgain_b    <= UNITY;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values,
         // so the fe-cycle pixel still sees the old working gains.
         r_vsync_prev <= in_vsync;
         if (w_fe) begin
            r_wgain_r <= r_gain;
            r_wgain_g <= g_gain;
            r_wgain_b <= b_gain;
         end
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_prod_r   <= '0;
         r_prod_g   <= '0;
         r_prod_b   <= '0;
         r_raw_r    <= '0;
         r_raw_g    <= '0;
         r_raw_b    <= '0;
         r_en_s1    <= 1'b0;
         r_href_s1  <= 1'b0;
         r_vsync_s1 <= 1'b0;
      end else begin
         r_prod_r   <= PROD_W'(in_r) * PROD_W'(r_wgain_r);
         r_prod_g   <= PROD_W'(in_g) * PROD_W'(r_wgain_g);
         r_prod_b   <= PROD_W'(in_b) * PROD_W'(r_wgain_b);
         r_raw_r    <= in_r;
         r_raw_g    <= in_g;
         r_raw_b    <= in_b;
         r_en_s1    <= awb_en;
         r_href_s1  <= in_href;
         r_vsync_s1 <= in_vsync;
      end
   end

   // Bypass keeps the raw pixel on the same two-stage path so latency never changes.
   always_comb begin
      w_pix_r = r_raw_r;
      w_pix_g = r_raw_g;
      w_pix_b = r_raw_b;
      if (r_en_s1) begin
         w_pix_r = f_round_sat(r_prod_r);
         w_pix_g = f_round_sat(r_prod_g);
         w_pix_b = f_round_sat(r_prod_b);
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         awb_r_o     <= '0;
         awb_g_o     <= '0;
         awb_b_o     <= '0;
         awb_href_o  <= 1'b0;
         awb_vsync_o <= 1'b0;
      end else begin
         awb_r_o     <= r_href_s1 ? w_pix_r : '0;
         awb_g_o     <= r_href_s1 ? w_pix_g : '0;
         awb_b_o     <= r_href_s1 ? w_pix_b : '0;
         awb_href_o  <= r_href_s1;
         awb_vsync_o <= r_vsync_s1;
      end
   end

   // A pixel on the fe cycle seeds the new frame instead of closing the old one.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_first_frame <= 1'b1;
         r_acc_r       <= '0;
         r_acc_g       <= '0;
         r_acc_b       <= '0;
         r_acc_cnt     <= '0;
         r_sum         <= '0;
         g_sum         <= '0;
         b_sum         <= '0;
         pix_cnt       <= '0;
         stat_valid    <= 1'b0;
      end else if (w_fe) begin
         r_first_frame <= 1'b0;
         stat_valid    <= ~r_first_frame;
         if (!r_first_frame) begin
            r_sum   <= r_acc_r;
            g_sum   <= r_acc_g;
            b_sum   <= r_acc_b;
            pix_cnt <= r_acc_cnt;
         end
         r_acc_r   <= in_href ? SUM_W'(in_r) : '0;
         r_acc_g   <= in_href ? SUM_W'(in_g) : '0;
         r_acc_b   <= in_href ? SUM_W'(in_b) : '0;
         r_acc_cnt <= in_href ? SUM_W'(1)    : '0;
      end else begin
         stat_valid <= 1'b0;
         if (in_href) begin
            r_acc_r   <= f_sat_add(r_acc_r, in_r);
            r_acc_g   <= f_sat_add(r_acc_g, in_g);
            r_acc_b   <= f_sat_add(r_acc_b, in_b);
            r_acc_cnt <= f_sat_add(r_acc_cnt, DATA_W'(1));
         end
      end
   end

endmodule
